// File: rtl/serial_negate_ctrl.sv
// Sequencer for the bit-serial two's-complement negator: parallel word in, LSB-first
// stream out, serial result collected back into a parallel word. Optional NEG_CHECK_EN self-check.
module serial_negate_ctrl #(
  parameter int unsigned W       = 12,
  parameter int unsigned SER_LAT = 1
) (
  input  logic         t_clk,
  input  logic         r,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         ser_bit,
  output logic         ser_first,
  input  logic         ser_y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy,
  output logic         err
);

  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DRAIN, S_DONE} state_t;

  state_t         r_state, w_state_nxt;
  logic [W-1:0]   r_sreg, w_sreg_nxt;
  logic [W-1:0]   r_res, w_res_nxt;
  logic [W-1:0]   r_out_data;
  logic [CW-1:0]  r_tx_cnt, w_tx_nxt;
  logic [CW-1:0]  r_rx_cnt, w_rx_nxt;
  logic           r_ser_bit, r_ser_first, r_in_ready, r_out_valid, r_busy;
  logic           w_cap, w_last_rx, w_accept;

  // Capture strobe: the SHIFT-cycle valid delayed to line up with the negator's output
  generate
    if (SER_LAT == 0) begin : g_nolat
      assign w_cap = (r_state == S_SHIFT);
    end else begin : g_lat
      logic [SER_LAT-1:0] r_vpipe;
      always_ff @(posedge t_clk or posedge r) begin
        if (r) r_vpipe <= '0;
        else   r_vpipe <= (r_vpipe << 1) | SER_LAT'(r_state == S_SHIFT);
      end
      assign w_cap = r_vpipe[SER_LAT-1];
    end
  endgenerate

  assign w_last_rx = w_cap && (r_rx_cnt == CW'(W - 1));
  assign w_accept  = (r_state == S_IDLE) && in_valid;

  always_ff @(posedge t_clk or posedge r) begin
    if (r) r_state <= S_IDLE;
    else   r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sreg_nxt  = r_sreg;
    w_tx_nxt    = r_tx_cnt;
    w_rx_nxt    = r_rx_cnt;
    w_res_nxt   = r_res;
    if (w_cap) begin
      w_res_nxt = {ser_y, r_res[W-1:1]};
      w_rx_nxt  = r_rx_cnt + CW'(1);
    end
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nxt = S_SHIFT;
          w_sreg_nxt  = in_data;
          w_tx_nxt    = '0;
          w_rx_nxt    = '0;
        end
      end
      S_SHIFT: begin
        w_sreg_nxt = {1'b0, r_sreg[W-1:1]};
        w_tx_nxt   = r_tx_cnt + CW'(1);
        if (r_tx_cnt == CW'(W - 1)) w_state_nxt = w_last_rx ? S_DONE : S_DRAIN;
      end
      S_DRAIN: if (w_last_rx) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and outputs, registered from next-state values
  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      r_sreg      <= '0;
      r_res       <= '0;
      r_out_data  <= '0;
      r_tx_cnt    <= '0;
      r_rx_cnt    <= '0;
      r_ser_bit   <= 1'b0;
      r_ser_first <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_sreg      <= w_sreg_nxt;
      r_res       <= w_res_nxt;
      r_tx_cnt    <= w_tx_nxt;
      r_rx_cnt    <= w_rx_nxt;
      r_ser_bit   <= (w_state_nxt == S_SHIFT) && w_sreg_nxt[0];
      r_ser_first <= w_accept;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
      r_busy      <= (w_state_nxt != S_IDLE);
      if (w_state_nxt == S_DONE && r_state != S_DONE) r_out_data <= w_res_nxt;
    end
  end

`ifdef NEG_CHECK_EN
  logic [W-1:0] r_exp;
  logic         r_err;
  // Expected result is latched at load and compared once the word is complete
  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      r_exp <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_accept) r_exp <= (~in_data) + W'(1);
      if (w_state_nxt == S_DONE && r_state != S_DONE && w_res_nxt != r_exp) r_err <= 1'b1;
    end
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign in_ready  = r_in_ready;
  assign ser_bit   = r_ser_bit;
  assign ser_first = r_ser_first;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;

endmodule

// File: tb/tb_serial_negate_ctrl.sv
// Bench for serial_negate_ctrl: three instances (SER_LAT 1, 0, 3), each driving its own
// serial negator model; directed words with hand-computed results.
module tb_serial_negate_ctrl;

  localparam int unsigned W = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                r;
  logic [2:0]          in_valid, in_ready, ser_bit, ser_first, ser_y;
  logic [2:0]          out_valid, out_ready, busy, err, corrupt;
  logic [2:0][W-1:0]   in_data, out_data;

  int sf_cnt[3] = '{0, 0, 0};
  int n_chk  = 0;
  int n_pass = 0;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_inst
      localparam int unsigned LAT = (g == 0) ? 1 : (g == 1) ? 0 : 3;

      serial_negate_ctrl #(.W(W), .SER_LAT(LAT)) u_dut (
        .t_clk     (clk),
        .r         (r),
        .in_valid  (in_valid[g]),
        .in_ready  (in_ready[g]),
        .in_data   (in_data[g]),
        .ser_bit   (ser_bit[g]),
        .ser_first (ser_first[g]),
        .ser_y     (ser_y[g]),
        .out_valid (out_valid[g]),
        .out_ready (out_ready[g]),
        .out_data  (out_data[g]),
        .busy      (busy[g]),
        .err       (err[g])
      );

      // Negator: copy through the first 1, invert afterwards; optional flip of bit 4
      logic       seen, s_cur, y_raw;
      logic [3:0] cnt, idx, mp;
      always_comb begin
        idx   = ser_first[g] ? 4'd0 : cnt;
        s_cur = ser_first[g] ? 1'b0 : seen;
        y_raw = ser_bit[g] ^ s_cur ^ (corrupt[g] && idx == 4'd4);
      end
      always @(posedge clk) begin
        if (r) begin
          seen <= 1'b0;
          cnt  <= 4'd0;
          mp   <= 4'd0;
        end else begin
          seen <= s_cur | ser_bit[g];
          cnt  <= idx + 4'd1;
          mp   <= {mp[2:0], y_raw};
        end
      end
      if (LAT == 0) begin : g_l0
        assign ser_y[g] = y_raw;
      end else begin : g_ln
        assign ser_y[g] = mp[LAT-1];
      end
    end
  endgenerate

  always @(negedge clk)
    for (int k = 0; k < 3; k++) if (ser_first[k]) sf_cnt[k]++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send(input int k, input logic [W-1:0] d, input string tag);
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(in_ready[k]), 32'd1);
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    @(posedge clk);
    #1 in_valid[k] = 1'b0;
  endtask

  // Counts edges after the accepting edge until out_valid rises (bounded)
  task automatic wait_result(input int k, input logic [W-1:0] exp, input int lat,
                             input int n0, input string tag);
    int n;
    n = n0;
    while (n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid[k]) break;
    end
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_data"}, 32'(out_data[k]), 32'(exp));
    if (out_ready[k]) begin
      @(posedge clk);
      #1 chk({tag, "_drop"}, 32'(out_valid[k]), 32'd0);
    end
  endtask

  task automatic word(input int k, input logic [W-1:0] d, input logic [W-1:0] exp,
                      input int lat, input string tag);
    int sf0;
    sf0 = sf_cnt[k];
    send(k, d, tag);
    wait_result(k, exp, lat, 0, tag);
    chk({tag, "_first"}, 32'(sf_cnt[k] - sf0), 32'd1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rdy"},  32'(in_ready[0]),  32'd1);
    chk({tag, "_ov"},   32'(out_valid[0]), 32'd0);
    chk({tag, "_od"},   32'(out_data[0]),  32'd0);
    chk({tag, "_sb"},   32'(ser_bit[0]),   32'd0);
    chk({tag, "_sf"},   32'(ser_first[0]), 32'd0);
    chk({tag, "_busy"}, 32'(busy[0]),      32'd0);
    chk({tag, "_err"},  32'(err[0]),       32'd0);
  endtask

  logic [W-1:0] cw [4] = '{12'h000, 12'h800, 12'h7FF, 12'hA5C};
  logic [W-1:0] ce [4] = '{12'h000, 12'h800, 12'h801, 12'h5A4};
  int           lats [3] = '{13, 12, 15};

  initial begin
    int       sf0;
    logic     ov;
    logic [W-1:0] d;
    r         = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = '1;
    corrupt   = '0;
    #2 r = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_reset_outs("rst");
    @(negedge clk) r = 1'b0;

    word(0, 12'h001, 12'hFFF, 13, "t1");

    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 4; i++)
        word(k, cw[i], ce[i], lats[k], $sformatf("t2_k%0d_%0d", k, i));

    // Stall in DONE with a second word already waiting
    sf0 = sf_cnt[0];
    out_ready[0] = 1'b0;
    send(0, 12'h0F0, "t3a");
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = 12'h005;
    wait_result(0, 12'hF10, 13, 0, "t3a");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t3_ov%0d", i),  32'(out_valid[0]), 32'd1);
      chk($sformatf("t3_od%0d", i),  32'(out_data[0]),  32'hF10);
      chk($sformatf("t3_rdy%0d", i), 32'(in_ready[0]),  32'd0);
    end
    out_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t3_idle_rdy", 32'(in_ready[0]),  32'd1);
    chk("t3_idle_bsy", 32'(busy[0]),      32'd0);
    chk("t3_idle_ov",  32'(out_valid[0]), 32'd0);
    chk("t3_hold_od",  32'(out_data[0]),  32'hF10);
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    wait_result(0, 12'hFFB, 13, 0, "t3b");
    chk("t3_first", 32'(sf_cnt[0] - sf0), 32'd2);

    // in_valid pulse during SHIFT must be ignored
    sf0 = sf_cnt[0];
    send(0, 12'h001, "t4");
    repeat (3) @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = 12'h123;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    wait_result(0, 12'hFFF, 13, 4, "t4");
    ov = 1'b0;
    repeat (20) begin
      @(negedge clk);
      ov |= out_valid[0];
    end
    chk("t4_noextra", 32'(ov), 32'd0);
    chk("t4_first", 32'(sf_cnt[0] - sf0), 32'd1);

    // Reset at bit 6 of a word
    send(0, 12'h0F0, "t5a");
    repeat (6) @(posedge clk);
    #1 r = 1'b1;
    #1 chk_reset_outs("t5_inrst");
    @(negedge clk) r = 1'b0;
    ov = 1'b0;
    repeat (20) begin
      @(negedge clk);
      ov |= out_valid[0];
    end
    chk("t5_noout", 32'(ov), 32'd0);
    word(0, 12'h003, 12'hFFD, 13, "t5b");

`ifdef NEG_CHECK_EN
    corrupt[0] = 1'b1;
    send(0, 12'h001, "t6c");
    wait_result(0, 12'hFEF, 13, 0, "t6c");
    chk("t6_err_set", 32'(err[0]), 32'd1);
    corrupt[0] = 1'b0;
    word(0, 12'h002, 12'hFFE, 13, "t6d");
    chk("t6_err_sticky", 32'(err[0]), 32'd1);
    @(negedge clk) r = 1'b1;
    @(negedge clk);
    chk("t6_err_clr", 32'(err[0]), 32'd0);
    r = 1'b0;
`else
    chk("t6_err_tied", 32'(err[0]), 32'd0);
`endif

    for (int i = 0; i < 100; i++) begin
      d = W'($urandom);
      word(0, d, (~d) + 12'd1, 13, $sformatf("rnd%0d", i));
    end
    chk("rnd_err", 32'(err[0]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
